// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared definitions for the pipeline hazard controller:
//               register-address width, flush-counter width, FSM state
//               encodings and the load-use hazard detection helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

  // Architectural register address width (x0..x31).
  localparam int REG_ADDR_WIDTH = 5;

  // Wide enough to hold FLUSH_CYCLES-1 for the legal range 1..7.
  localparam int FLUSH_CNT_WIDTH = 3;

  // FSM state encodings (also visible on the state output port).
  localparam int STATE_WIDTH = 2;
  typedef logic [STATE_WIDTH-1:0] state_t;

  localparam state_t ST_RUN   = 2'd0;
  localparam state_t ST_FLUSH = 2'd1;
  localparam state_t ST_WAIT  = 2'd2;

  // A load in EX whose destination is read by the instruction in ID.
  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  function automatic logic load_use_hazard(
    input logic                      mem_read,
    input logic [REG_ADDR_WIDTH-1:0] rd,
    input logic [REG_ADDR_WIDTH-1:0] rs1,
    input logic                      use_rs1,
    input logic [REG_ADDR_WIDTH-1:0] rs2,
    input logic                      use_rs2
  );
    logic rs1_hit;
    logic rs2_hit;
    rs1_hit = use_rs1 && (rs1 == rd);
    rs2_hit = use_rs2 && (rs2 == rd);
    return mem_read && (rd != '0) && (rs1_hit || rs2_hit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones. A synchronous clear has
//               priority over increment. State changes on the falling edge of
//               clk to stay aligned with the pipeline registers.
// Ports       : clk   - clock (falling edge active)
//               rst   - asynchronous active-high reset, clears the count
//               clr   - synchronous clear
//               inc   - increment request for this cycle
//               count - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. Resolves, in priority order,
//               data-memory stalls, EX-stage redirects (branch/jump flush)
//               and load-use hazards, and keeps saturating statistics of
//               hold cycles and accepted redirects.
//               All state updates happen on the falling edge of clk.
// Ports       : clk, rst                  - clock (falling edge), async reset
//               id_rs1/id_rs2, id_use_*   - ID-stage source operands
//               ex_mem_read, ex_rd        - load in EX and its destination
//               ex_redirect               - taken branch/jump resolved in EX
//               mem_req, mem_ready        - MEM-stage access and completion
//               cnt_clr                   - synchronous statistics clear
//               pc_hold..exmem_hold       - freeze PC / pipeline registers
//               ifid_flush, idex_flush    - insert bubble into pipeline reg
//               state                     - RUN=0, FLUSH=1, WAIT=2
//               stall_cnt, redirect_cnt   - saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,   // legal range 1..7
  parameter int CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_redirect,
  input  logic                      mem_req,
  input  logic                      mem_ready,
  input  logic                      cnt_clr,
  output logic                      pc_hold,
  output logic                      ifid_hold,
  output logic                      idex_hold,
  output logic                      exmem_hold,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic [STATE_WIDTH-1:0]    state,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      redirect_cnt
);

  // Flush cycles remaining after the redirect cycle itself.
  localparam logic [FLUSH_CNT_WIDTH-1:0] C_FLUSH_INIT =
    FLUSH_CNT_WIDTH'(FLUSH_CYCLES - 1);
  localparam bit C_MULTI_FLUSH = (FLUSH_CYCLES > 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                     r_state;
  state_t                     r_ret_state;   // state to resume after WAIT
  logic [FLUSH_CNT_WIDTH-1:0] r_flush_left;

  state_t                     w_next_state;
  state_t                     w_next_ret_state;
  logic [FLUSH_CNT_WIDTH-1:0] w_next_flush_left;

  // --------------------------------------------------------------------------
  // Shared decode
  // --------------------------------------------------------------------------
  logic   w_mem_stall;
  logic   w_load_use;
  state_t w_eff_state;
  logic   w_redirect_acc;

  assign w_mem_stall = mem_req && !mem_ready;

  assign w_load_use = load_use_hazard(ex_mem_read, ex_rd,
                                      id_rs1, id_use_rs1,
                                      id_rs2, id_use_rs2);

  // WAIT is transparent: once memory completes, behaviour is that of the
  // state that was interrupted, in the very same cycle.
  assign w_eff_state = (r_state == ST_WAIT) ? r_ret_state : r_state;

  // Redirects are only honoured from (effective) RUN; during a flush the
  // instruction in EX is already a bubble-to-be.
  assign w_redirect_acc = !rst && !w_mem_stall && ex_redirect &&
                          (w_eff_state != ST_FLUSH);

  // --------------------------------------------------------------------------
  // Process 1: state register
  // --------------------------------------------------------------------------
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_ret_state  <= ST_RUN;
      r_flush_left <= '0;
    end else begin
      r_state      <= w_next_state;
      r_ret_state  <= w_next_ret_state;
      r_flush_left <= w_next_flush_left;
    end
  end

  // --------------------------------------------------------------------------
  // Process 2: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state      = r_state;
    w_next_ret_state  = r_ret_state;
    w_next_flush_left = r_flush_left;

    if (w_mem_stall) begin
      // Park in WAIT. Re-entering WAIT from WAIT must keep the original
      // return state; flush_left stays frozen.
      w_next_state = ST_WAIT;
      if (r_state != ST_WAIT) begin
        w_next_ret_state = r_state;
      end
    end else begin
      case (w_eff_state)
        ST_FLUSH: begin
          if (r_flush_left != '0) begin
            w_next_flush_left = r_flush_left - 1'b1;
          end
          // Leave on the last counted cycle; a zero count (unreachable in
          // normal operation) also falls back to RUN rather than sticking.
          w_next_state = (r_flush_left <= FLUSH_CNT_WIDTH'(1)) ? ST_RUN
                                                               : ST_FLUSH;
        end
        default: begin
          if (ex_redirect) begin
            w_next_flush_left = C_FLUSH_INIT;
            w_next_state      = C_MULTI_FLUSH ? ST_FLUSH : ST_RUN;
          end else begin
            // Load-use costs a single bubble and never leaves RUN.
            w_next_state = ST_RUN;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Process 3: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    idex_hold  = 1'b0;
    exmem_hold = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    // Reset dominates everything, including an in-flight memory stall.
    if (!rst) begin
      if (w_mem_stall) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_hold  = 1'b1;
        exmem_hold = 1'b1;
      end else if (w_eff_state == ST_FLUSH) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_redirect_acc) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (w_load_use) begin
        // Freeze fetch/decode and push a bubble into EX for one cycle.
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  assign state = r_state;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (pc_hold),
    .count (stall_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_redirect_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (w_redirect_acc),
    .count (redirect_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl (FLUSH_CYCLES=3,
//               CNT_WIDTH=16). Inputs change just after the falling (active)
//               edge; outputs are sampled on the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  // Output bundle: {pc_hold, ifid_hold, idex_hold, exmem_hold,
  //                 ifid_flush, idex_flush}
  localparam logic [5:0] O_NONE     = 6'b000000;
  localparam logic [5:0] O_HOLD_ALL = 6'b111100;
  localparam logic [5:0] O_FLUSH    = 6'b000011;
  localparam logic [5:0] O_LOADUSE  = 6'b110001;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic             mem_req, mem_ready, cnt_clr;
  logic             pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic             ifid_flush, idex_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, redirect_cnt;
  logic [5:0]       outs;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  assign outs = {pc_hold, ifid_hold, idex_hold, exmem_hold,
                 ifid_flush, idex_flush};

  hazard_ctrl #(
    .FLUSH_CYCLES (3),
    .CNT_WIDTH    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .cnt_clr      (cnt_clr),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .idex_hold    (idex_hold),
    .exmem_hold   (exmem_hold),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_checks = n_checks + 1;
    assert (obs === expv) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_rd = '0; ex_redirect = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic sample();
    @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset: outputs forced low even with every request active -------
    idle();
    ex_redirect = 1'b1; mem_req = 1'b1; ex_mem_read = 1'b1;
    ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #2;
    chk("rst_outs", 32'(outs), 32'(O_NONE));
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_redirect_cnt", 32'(redirect_cnt), 32'd0);
    idle();
    next_cycle();
    rst = 1'b0;

    // ---- load-use on rs2 --------------------------------------------------
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    sample();
    chk("lu_rs2_outs", 32'(outs), 32'(O_LOADUSE));
    chk("lu_rs2_state", 32'(state), 32'd0);
    next_cycle();
    idle();
    sample();
    chk("lu_after_outs", 32'(outs), 32'(O_NONE));
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    next_cycle();

    // ---- x0 load, unused operand, then real rs1 hazard -------------------
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    sample();
    chk("x0_outs", 32'(outs), 32'(O_NONE));
    next_cycle();
    ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b0;
    sample();
    chk("nouse_outs", 32'(outs), 32'(O_NONE));
    next_cycle();
    id_use_rs1 = 1'b1;
    sample();
    chk("lu_rs1_outs", 32'(outs), 32'(O_LOADUSE));
    next_cycle();
    idle();
    sample();
    chk("lu_rs1_stall_cnt", 32'(stall_cnt), 32'd2);
    next_cycle();

    // ---- redirect, 3 flush cycles; redirect/load-use ignored in FLUSH ----
    ex_redirect = 1'b1;
    sample();
    chk("redir0_outs", 32'(outs), 32'(O_FLUSH));
    chk("redir0_state", 32'(state), 32'd0);
    next_cycle();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    sample();
    chk("redir1_outs", 32'(outs), 32'(O_FLUSH));
    chk("redir1_state", 32'(state), 32'd1);
    chk("redir1_redirect_cnt", 32'(redirect_cnt), 32'd1);
    next_cycle();
    sample();
    chk("redir2_outs", 32'(outs), 32'(O_FLUSH));
    chk("redir2_state", 32'(state), 32'd1);
    next_cycle();
    idle();
    sample();
    chk("redir3_outs", 32'(outs), 32'(O_NONE));
    chk("redir3_state", 32'(state), 32'd0);
    chk("redir3_redirect_cnt", 32'(redirect_cnt), 32'd1);
    chk("redir3_stall_cnt", 32'(stall_cnt), 32'd2);
    next_cycle();

    // ---- memory stall over a pending redirect ----------------------------
    mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("mstall_outs", 32'(outs), 32'(O_HOLD_ALL));
      chk("mstall_state", 32'(state), (i == 0) ? 32'd0 : 32'd2);
      next_cycle();
    end
    mem_ready = 1'b1;
    sample();
    chk("mready_outs", 32'(outs), 32'(O_FLUSH));
    chk("mready_state", 32'(state), 32'd2);
    chk("mready_stall_cnt", 32'(stall_cnt), 32'd6);
    next_cycle();
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    sample();
    chk("wflush1_outs", 32'(outs), 32'(O_FLUSH));
    chk("wflush1_state", 32'(state), 32'd1);
    chk("wflush1_redirect_cnt", 32'(redirect_cnt), 32'd2);
    next_cycle();
    // flush_left is now 1: stall interrupts the last flush cycle
    mem_req = 1'b1;
    sample();
    chk("fstall_outs", 32'(outs), 32'(O_HOLD_ALL));
    chk("fstall_state", 32'(state), 32'd1);
    next_cycle();
    mem_ready = 1'b1;
    sample();
    chk("fresume_outs", 32'(outs), 32'(O_FLUSH));
    chk("fresume_state", 32'(state), 32'd2);
    next_cycle();
    idle();
    sample();
    chk("fdone_outs", 32'(outs), 32'(O_NONE));
    chk("fdone_state", 32'(state), 32'd0);
    chk("fdone_stall_cnt", 32'(stall_cnt), 32'd7);
    next_cycle();

    // ---- load-use and redirect together: flush wins ----------------------
    ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9;
    id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    sample();
    chk("lu_redir_outs", 32'(outs), 32'(O_FLUSH));
    next_cycle();
    idle();
    sample();
    chk("lu_redir_state", 32'(state), 32'd1);
    chk("lu_redir_redirect_cnt", 32'(redirect_cnt), 32'd3);
    chk("lu_redir_stall_cnt", 32'(stall_cnt), 32'd7);
    next_cycle();

    // ---- reset mid-FLUSH -------------------------------------------------
    rst = 1'b1;
    #1;
    chk("rst_flush_state", 32'(state), 32'd0);
    chk("rst_flush_outs", 32'(outs), 32'(O_NONE));
    chk("rst_flush_redirect_cnt", 32'(redirect_cnt), 32'd0);
    next_cycle();
    rst = 1'b0;
    sample();
    chk("post_rst_flush_outs", 32'(outs), 32'(O_NONE));
    chk("post_rst_flush_state", 32'(state), 32'd0);
    next_cycle();

    // ---- saturation of stall_cnt via a long memory stall -----------------
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (65534) @(negedge clk);
    #1;
    chk("sat_preset", 32'(stall_cnt), 32'h0000_FFFE);
    chk("sat_state", 32'(state), 32'd2);
    repeat (3) @(negedge clk);
    #1;
    chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
    cnt_clr = 1'b1;
    sample();
    chk("clr_outs", 32'(outs), 32'(O_HOLD_ALL));
    next_cycle();
    chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
    cnt_clr = 1'b0;

    // ---- reset while in WAIT ---------------------------------------------
    rst = 1'b1;
    #1;
    chk("rst_wait_state", 32'(state), 32'd0);
    chk("rst_wait_outs", 32'(outs), 32'(O_NONE));
    next_cycle();
    rst = 1'b0;
    idle();
    sample();
    chk("post_rst_wait_outs", 32'(outs), 32'(O_NONE));
    chk("post_rst_wait_state", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 1, number of cycles flush is asserted per redirect (legal 1..7).
REQ-002 Parameter CNT_WIDTH, default 16, width of statistics counters.
REQ-003 clk  in  1  single clock; all state updates on the falling edge, matching the pipeline registers.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 id_rs1, id_rs2  in  5 each  source register addresses of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2.
REQ-007 ex_mem_read  in  1  instruction in EX is a load.
REQ-008 ex_rd  in  5  destination register of the instruction in EX.
REQ-009 ex_redirect  in  1  taken branch or jump resolved in EX.
REQ-010 mem_req, mem_ready  in  1 each  data-memory access in MEM and its completion.
REQ-011 cnt_clr  in  1  synchronous clear of statistics counters.
REQ-012 pc_hold, ifid_hold, idex_hold, exmem_hold  out  1 each  freeze PC or the named pipeline register.
REQ-013 ifid_flush, idex_flush  out  1 each  load a bubble (all zeros) into the named pipeline register.
REQ-014 state  out  2  current FSM state: RUN=0, FLUSH=1, WAIT=2.
REQ-015 stall_cnt, redirect_cnt  out  CNT_WIDTH each  saturating statistics.

Function
REQ-016 mem_stall = mem_req AND NOT mem_ready; when mem_stall=1, in any state, all four holds = 1 and both flushes = 0.
REQ-017 On mem_stall, next state = WAIT and ret_state saves RUN or FLUSH; flush_left is frozen while in WAIT.
REQ-018 Effective state = ret_state when state=WAIT, else state.
REQ-019 In WAIT with mem_stall=0, outputs follow the effective-state rules in that same cycle, and next state = ret_state (or FLUSH/RUN per those rules).
REQ-020 Effective RUN, no mem_stall, ex_redirect=1: ifid_flush = idex_flush = 1, holds = 0, load-use is ignored, and flush_left loads FLUSH_CYCLES-1.
REQ-021 Under REQ-020, next state = FLUSH when FLUSH_CYCLES>1, else RUN.
REQ-022 Load-use hazard = ex_mem_read AND ex_rd != 0 AND ((id_use_rs1 AND id_rs1==ex_rd) OR (id_use_rs2 AND id_rs2==ex_rd)).
REQ-023 Effective RUN, no mem_stall, no redirect, hazard=1: pc_hold = ifid_hold = 1 and idex_flush = 1 for exactly that cycle; state stays RUN.
REQ-024 Effective FLUSH, no mem_stall: ifid_flush = idex_flush = 1, flush_left decrements, and next state = RUN when flush_left==1.
REQ-025 In FLUSH, ex_redirect and the load-use hazard are ignored.
REQ-026 Priority: rst > mem_stall > ex_redirect > load-use.
REQ-027 All unlisted outputs = 0 in every case.
REQ-028 stall_cnt increments in each cycle with pc_hold=1.
REQ-029 redirect_cnt increments once per accepted redirect (REQ-020).
REQ-030 Both counters saturate at all-ones; cnt_clr clears them and takes priority over increment.

Reset
REQ-031 Asserting rst immediately sets state = RUN, ret_state = RUN, flush_left = 0, and both counters = 0.
REQ-032 While rst = 1, all hold and flush outputs = 0 regardless of inputs.
REQ-033 rst asserted mid-FLUSH or mid-WAIT abandons the sequence with no residual flush or hold after release.

Structure
REQ-034 State encodings and the flush-counter width are defined in Defines.v; register address width uses the existing REG_ADDR_WIDTH define.
REQ-035 One sub-module, sat_counter (parameter width; inputs clr and inc), is instantiated twice for the statistics counters.

Verification
REQ-036 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of pc_hold=ifid_hold=idex_flush=1, then normal; stall_cnt=1.
REQ-037 ex_rd=0 load with id_rs1=0 -> no stall; an x0 match produces no hazard.
REQ-038 ex_redirect=1 with FLUSH_CYCLES=3 -> flushes asserted for 3 consecutive cycles, states RUN->FLUSH->FLUSH->RUN, redirect_cnt=1.
REQ-039 mem_req=1, mem_ready=0 for 4 cycles while ex_redirect=1 -> 4 cycles of all holds with no flush, then flush on the cycle mem_ready=1.
REQ-040 Load-use and redirect in the same cycle -> flush only, no hold; mem_stall during FLUSH at flush_left=1 -> after WAIT, one more flush cycle, then RUN.
REQ-041 stall_cnt preset to 0xFFFE via 2^16-2 hold cycles, then 3 more hold cycles -> stall_cnt=0xFFFF; cnt_clr=1 together with a hold -> 0; rst in WAIT -> state=0 and outputs 0 immediately.
